// File: rtl/xcorr_peak_find_if.sv
// rtl/xcorr_peak_find_if.sv - sample, control and peak-report bundle for xcorr_peak_find
interface xcorr_peak_find_if #(
    parameter int WND_MAX = 64,
    parameter int CORR_W  = 24,
    parameter int DATA_W  = 18,
    parameter int HOLD_W  = 16
);
    localparam int IDX_W = $clog2(WND_MAX);

    logic                in_valid;
    logic [CORR_W-1:0]   corr_in;
    logic [DATA_W-1:0]   data_i;
    logic [DATA_W-1:0]   data_q;
    logic [CORR_W-1:0]   thr_lvl;
    logic [IDX_W:0]      wnd_len;
    logic [HOLD_W-1:0]   holdoff;
    logic                out_valid;
    logic [DATA_W-1:0]   odata_i;
    logic [DATA_W-1:0]   odata_q;
    logic                osop;
    logic                peak_strobe;
    logic [CORR_W-1:0]   peak_val;
    logic [IDX_W-1:0]    peak_idx;
    logic                busy;

    modport master (
        output in_valid, corr_in, data_i, data_q, thr_lvl, wnd_len, holdoff,
        input  out_valid, odata_i, odata_q, osop, peak_strobe, peak_val, peak_idx, busy
    );

    modport slave (
        input  in_valid, corr_in, data_i, data_q, thr_lvl, wnd_len, holdoff,
        output out_valid, odata_i, odata_q, osop, peak_strobe, peak_val, peak_idx, busy
    );
endinterface

// File: rtl/xcorr_peak_find.sv
// rtl/xcorr_peak_find.sv - windowed correlation peak search with aligned delayed I/Q output
module xcorr_peak_find #(
    parameter int WND_MAX = 64,
    parameter int CORR_W  = 24,
    parameter int DATA_W  = 18,
    parameter int HOLD_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    xcorr_peak_find_if.slave bus
);
    localparam int IDX_W = $clog2(WND_MAX);
    localparam int DEPTH = WND_MAX + 1;
    localparam int AW    = $clog2(DEPTH);
    localparam logic [IDX_W:0] WND_MAX_V = (IDX_W+1)'(WND_MAX);
    localparam logic [AW-1:0]  LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [AW-1:0]  FULL_CNT  = AW'(DEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_SEARCH, ST_HOLD} state_t;

    state_t              state_q, state_d;
    logic [AW-1:0]       ptr_q, ptr_d;
    logic [AW-1:0]       fill_q, fill_d;
    logic [IDX_W:0]      w_eff_q, w_eff_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [CORR_W-1:0]   cand_val_q, cand_val_d;
    logic [IDX_W-1:0]    cand_idx_q, cand_idx_d;
    logic [AW-1:0]       cand_addr_q, cand_addr_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic                peak_strobe_q, peak_strobe_d;
    logic [CORR_W-1:0]   peak_val_q, peak_val_d;
    logic [IDX_W-1:0]    peak_idx_q, peak_idx_d;
    logic                out_valid_q, out_valid_d;
    logic                osop_q, osop_d;
    logic [DATA_W-1:0]   out_i_q, out_i_d;
    logic [DATA_W-1:0]   out_q_q, out_q_d;

    // Delay line plus one marker bit per slot; the marker tags the peak sample
    // so any number of pending peaks drain in order with the data itself.
    logic [DATA_W-1:0]   ring_i_mem [DEPTH];
    logic [DATA_W-1:0]   ring_q_mem [DEPTH];
    logic                sop_mark   [DEPTH];

    logic [IDX_W:0]      wnd_clamped;
    logic                filled;
    logic                start_hit;
    logic                in_window;
    logic                take;
    logic [IDX_W-1:0]    cur_idx;
    logic [IDX_W:0]      win_last;
    logic                win_end;
    logic [CORR_W-1:0]   sel_val;
    logic [IDX_W-1:0]    sel_idx;
    logic [AW-1:0]       sel_addr;

    // Window-length clamp, candidate compare and window-end detection for this sample
    always_comb begin
        if (bus.wnd_len == '0) begin
            wnd_clamped = (IDX_W+1)'(1);
        end else if (bus.wnd_len > WND_MAX_V) begin
            wnd_clamped = WND_MAX_V;
        end else begin
            wnd_clamped = bus.wnd_len;
        end
        filled    = (fill_q == FULL_CNT);
        start_hit = (state_q == ST_IDLE) && bus.in_valid && (bus.corr_in > bus.thr_lvl);
        in_window = start_hit || ((state_q == ST_SEARCH) && bus.in_valid);
        cur_idx   = (state_q == ST_SEARCH) ? idx_q : '0;
        win_last  = (state_q == ST_SEARCH) ? w_eff_q : wnd_clamped;
        take      = start_hit || ((state_q == ST_SEARCH) && (bus.corr_in > cand_val_q));
        sel_val   = take ? bus.corr_in : cand_val_q;
        sel_idx   = take ? cur_idx : cand_idx_q;
        sel_addr  = take ? ptr_q : cand_addr_q;
        win_end   = in_window && ({1'b0, cur_idx} == (win_last - 1'b1));
    end

    // State register and datapath flops
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            ptr_q         <= '0;
            fill_q        <= '0;
            w_eff_q       <= '0;
            idx_q         <= '0;
            cand_val_q    <= '0;
            cand_idx_q    <= '0;
            cand_addr_q   <= '0;
            hold_q        <= '0;
            peak_strobe_q <= 1'b0;
            peak_val_q    <= '0;
            peak_idx_q    <= '0;
            out_valid_q   <= 1'b0;
            osop_q        <= 1'b0;
            out_i_q       <= '0;
            out_q_q       <= '0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            fill_q        <= fill_d;
            w_eff_q       <= w_eff_d;
            idx_q         <= idx_d;
            cand_val_q    <= cand_val_d;
            cand_idx_q    <= cand_idx_d;
            cand_addr_q   <= cand_addr_d;
            hold_q        <= hold_d;
            peak_strobe_q <= peak_strobe_d;
            peak_val_q    <= peak_val_d;
            peak_idx_q    <= peak_idx_d;
            out_valid_q   <= out_valid_d;
            osop_q        <= osop_d;
            out_i_q       <= out_i_d;
            out_q_q       <= out_q_d;
        end
    end

    // Ring write of the incoming sample; the marker of the decided peak is set last so it wins
    always_ff @(posedge clk) begin
        if (!rst && bus.in_valid) begin
            ring_i_mem[ptr_q] <= bus.data_i;
            ring_q_mem[ptr_q] <= bus.data_q;
            sop_mark[ptr_q]   <= 1'b0;
        end
        if (!rst && win_end) begin
            sop_mark[sel_addr] <= 1'b1;
        end
    end

    // Next-state logic: threshold only matters in IDLE, HOLD counts valid samples
    always_comb begin
        state_d = state_q;
        if (bus.in_valid) begin
            case (state_q)
                ST_IDLE:   if (start_hit) state_d = win_end ? ST_HOLD : ST_SEARCH;
                ST_SEARCH: if (win_end) state_d = ST_HOLD;
                ST_HOLD:   if (hold_q <= HOLD_W'(1)) state_d = ST_IDLE;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    // Datapath next values; everything except the pulses holds on invalid cycles
    always_comb begin
        ptr_d         = ptr_q;
        fill_d        = fill_q;
        w_eff_d       = w_eff_q;
        idx_d         = idx_q;
        cand_val_d    = cand_val_q;
        cand_idx_d    = cand_idx_q;
        cand_addr_d   = cand_addr_q;
        hold_d        = hold_q;
        peak_strobe_d = 1'b0;
        peak_val_d    = peak_val_q;
        peak_idx_d    = peak_idx_q;
        out_valid_d   = 1'b0;
        osop_d        = 1'b0;
        out_i_d       = out_i_q;
        out_q_d       = out_q_q;
        if (bus.in_valid) begin
            ptr_d = (ptr_q == LAST_ADDR) ? '0 : ptr_q + 1'b1;
            if (!filled) begin
                fill_d = fill_q + 1'b1;
            end else begin
                out_valid_d = 1'b1;
                out_i_d     = ring_i_mem[ptr_q];
                out_q_d     = ring_q_mem[ptr_q];
                osop_d      = sop_mark[ptr_q];
            end
            if (start_hit) begin
                w_eff_d = wnd_clamped;
            end
            if (in_window) begin
                cand_val_d  = sel_val;
                cand_idx_d  = sel_idx;
                cand_addr_d = sel_addr;
                idx_d       = cur_idx + 1'b1;
            end
            if (win_end) begin
                peak_strobe_d = 1'b1;
                peak_val_d    = sel_val;
                peak_idx_d    = sel_idx;
                hold_d        = bus.holdoff;
            end else if ((state_q == ST_HOLD) && (hold_q != '0)) begin
                hold_d = hold_q - 1'b1;
            end
        end
    end

    // Outputs: registered datapath values, busy decoded from state
    always_comb begin
        bus.out_valid   = out_valid_q;
        bus.odata_i     = out_i_q;
        bus.odata_q     = out_q_q;
        bus.osop        = osop_q;
        bus.peak_strobe = peak_strobe_q;
        bus.peak_val    = peak_val_q;
        bus.peak_idx    = peak_idx_q;
        bus.busy        = (state_q != ST_IDLE);
    end
endmodule
